// File: rtl/multi_rate_tick_gen_pkg.sv
// Shared constants for the multi-rate tick generator: board clock, counter width
// and the common half-periods used by timers, blinkers and display refresh.
package multi_rate_tick_gen_pkg;

  localparam int CLK_HZ    = 40_000_000;
  localparam int DEF_CNT_W = 26;

  // Half-period in clk cycles for a square wave of the given frequency.
  function automatic int half_for_hz(input int hz);
    return CLK_HZ / (2 * hz);
  endfunction

  localparam int HALF_1HZ     = half_for_hz(1);   // 20_000_000
  localparam int HALF_2HZ     = half_for_hz(2);   // 10_000_000
  localparam int HALF_10HZ    = half_for_hz(10);  //  2_000_000
  localparam int DEF_HALF_CYC = HALF_1HZ;

endpackage

// File: rtl/multi_rate_tick_gen_tick_channel.sv
// One divider channel: half-period counter, square wave and rise tick, with a
// load port that swaps in a new half-period on the edge the top chooses.
module tick_channel
  import multi_rate_tick_gen_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DEF_HALF = DEF_HALF_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             sq,
  output logic             tick,
  output logic             at_term
);

  logic [CNT_W-1:0] half_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sq_reg;
  logic             tick_reg;

  assign at_term = (cnt_reg == half_reg - CNT_W'(1));
  assign sq      = sq_reg;
  assign tick    = tick_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_reg <= CNT_W'(DEF_HALF);
      cnt_reg  <= '0;
      sq_reg   <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (sync || !en) begin
        cnt_reg <= '0;
        sq_reg  <= 1'b0;
      end else if (at_term) begin
        cnt_reg  <= '0;
        sq_reg   <= ~sq_reg;
        tick_reg <= ~sq_reg;
      end else begin
        // A load always restarts the phase so the new period never produces a runt.
        cnt_reg <= load ? '0 : cnt_reg + CNT_W'(1);
      end
      if (load) begin
        half_reg <= load_val;
      end
    end
  end

endmodule

// File: rtl/multi_rate_tick_gen.sv
// NUM_CH programmable square-wave/tick generators sharing one config slot that
// is applied only at a glitch-free point of the target channel.
module multi_rate_tick_gen
  import multi_rate_tick_gen_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  CNT_W    = DEF_CNT_W,
  parameter int  DEF_HALF = DEF_HALF_CYC,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_all,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] sq,
  output logic [NUM_CH-1:0] tick
);

  logic              pend_reg;
  logic [CH_W-1:0]   pend_ch_reg;
  logic [CNT_W-1:0]  pend_half_reg;
  logic              cfg_ready_reg;
  logic              cfg_err_reg;
  logic [NUM_CH-1:0] at_term;
  logic [NUM_CH-1:0] load;
  logic              apply;
  logic              cfg_ok;

  assign cfg_ok    = (cfg_half != '0) && (int'(cfg_ch) < NUM_CH);
  assign apply     = |load;
  assign cfg_ready = cfg_ready_reg;
  assign cfg_err   = cfg_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // Safe apply points: terminal count, channel idle, or a global restart.
      assign load[gi] = pend_reg && (pend_ch_reg == CH_W'(gi)) &&
                        (at_term[gi] || !ch_en[gi] || sync_all);

      tick_channel #(
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF)
      ) u_ch (
        .clk      (clk),
        .reset    (reset),
        .en       (ch_en[gi]),
        .sync     (sync_all),
        .load     (load[gi]),
        .load_val (pend_half_reg),
        .sq       (sq[gi]),
        .tick     (tick[gi]),
        .at_term  (at_term[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_reg      <= 1'b0;
      pend_ch_reg   <= '0;
      pend_half_reg <= '0;
      cfg_ready_reg <= 1'b1;
      cfg_err_reg   <= 1'b0;
    end else begin
      cfg_err_reg <= 1'b0;
      if (apply) begin
        pend_reg      <= 1'b0;
        cfg_ready_reg <= 1'b1;
      end else if (cfg_valid && cfg_ready_reg) begin
        if (cfg_ok) begin
          pend_reg      <= 1'b1;
          cfg_ready_reg <= 1'b0;
          pend_ch_reg   <= cfg_ch;
          pend_half_reg <= cfg_half;
        end else begin
          cfg_err_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// Randomised and directed bench for multi_rate_tick_gen against a toggle-schedule
// reference model (each channel tracks the edge number of its next sq toggle).
module tb_multi_rate_tick_gen;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 8;
  localparam int DEF_HALF = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_all;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic              cfg_err;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] tick;

  // Second instance with a non-power-of-two channel count to reach the range reject.
  logic              v3;
  logic [1:0]        c3;
  logic [CNT_W-1:0]  h3;
  logic              r3;
  logic              e3;
  logic [2:0]        sq3;
  logic [2:0]        tk3;

  multi_rate_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) u_dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .sync_all(sync_all),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .cfg_err(cfg_err), .sq(sq), .tick(tick)
  );

  multi_rate_tick_gen #(.NUM_CH(3), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) u_dut3 (
    .clk(clk), .reset(reset), .ch_en(3'b000), .sync_all(1'b0),
    .cfg_valid(v3), .cfg_ready(r3), .cfg_ch(c3),
    .cfg_half(h3), .cfg_err(e3), .sq(sq3), .tick(tk3)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int k     = 0;

  int          half_m [NUM_CH];
  int          due_m  [NUM_CH];
  bit [NUM_CH-1:0] sq_m;
  bit [NUM_CH-1:0] tick_m;
  bit          pend_m, ready_m, err_m;
  int          pch_m, phalf_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      half_m[i] = DEF_HALF;
      due_m[i]  = k + DEF_HALF;
    end
    sq_m    = '0;
    tick_m  = '0;
    pend_m  = 1'b0;
    ready_m = 1'b1;
    err_m   = 1'b0;
  endtask

  task automatic model_edge();
    bit apply;
    bit pre_ready;
    pre_ready = ready_m;
    apply     = 1'b0;
    err_m     = 1'b0;
    if (pend_m)
      apply = sync_all || !ch_en[pch_m] || (k == due_m[pch_m]);
    if (apply) begin
      half_m[pch_m] = phalf_m;
      pend_m  = 1'b0;
      ready_m = 1'b1;
      $display("edge %0d: apply ch=%0d N=%0d", k, pch_m, phalf_m);
    end else if (pre_ready && cfg_valid) begin
      if (cfg_half == 0 || int'(cfg_ch) >= NUM_CH) begin
        err_m = 1'b1;
        $display("edge %0d: reject ch=%0d N=%0d", k, cfg_ch, cfg_half);
      end else begin
        pend_m  = 1'b1;
        ready_m = 1'b0;
        pch_m   = int'(cfg_ch);
        phalf_m = int'(cfg_half);
        $display("edge %0d: accept ch=%0d N=%0d", k, pch_m, phalf_m);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      tick_m[i] = 1'b0;
      if (sync_all || !ch_en[i]) begin
        sq_m[i]  = 1'b0;
        due_m[i] = k + half_m[i];
      end else if (k == due_m[i]) begin
        sq_m[i]   = !sq_m[i];
        tick_m[i] = sq_m[i];
        due_m[i]  = k + half_m[i];
      end
    end
  endtask

  task automatic compare_all();
    chk("sq",        32'(sq),        32'(sq_m));
    chk("tick",      32'(tick),      32'(tick_m));
    chk("cfg_ready", 32'(cfg_ready), 32'(ready_m));
    chk("cfg_err",   32'(cfg_err),   32'(err_m));
  endtask

  task automatic step();
    @(posedge clk);
    k++;
    if (reset) model_reset();
    else       model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    bit found;
    reset = 1'b1; ch_en = '0; sync_all = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
    v3 = 1'b0; c3 = '0; h3 = '0;
    model_reset();
    step();
    step();
    chk("rst_sq",    32'(sq),        32'h0);
    chk("rst_tick",  32'(tick),      32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    chk("rst_err",   32'(cfg_err),   32'h0);

    // 1: all channels in phase, first rise on the 4th edge, fall on the 8th
    reset = 1'b0;
    ch_en = 4'hF;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 4) begin
        chk("t1_rise_sq",   32'(sq),   32'hF);
        chk("t1_rise_tick", 32'(tick), 32'hF);
      end
      if (e == 5) chk("t1_tick_clr", 32'(tick), 32'h0);
      if (e == 8) chk("t1_fall",     32'(sq),   32'h0);
    end

    // 2: reprogram ch1 mid-phase
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd2;
    step();
    cfg_valid = 1'b0;
    chk("t2_ready_low", 32'(cfg_ready), 32'h0);
    for (int e = 0; e < 12; e++) step();

    // 3: zero half-period rejected; range reject on the 3-channel instance
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd0;
    v3 = 1'b1; c3 = 2'd3; h3 = 8'd2;
    step();
    chk("t3_err",    32'(cfg_err),   32'h1);
    chk("t3_ready",  32'(cfg_ready), 32'h1);
    chk("t3_err3",   32'(e3),        32'h1);
    chk("t3_ready3", 32'(r3),        32'h1);
    cfg_valid = 1'b0;
    c3 = 2'd2;
    step();
    chk("t3_err_clr", 32'(cfg_err), 32'h0);
    chk("t3_ok3_err", 32'(e3),      32'h0);
    chk("t3_ok3_rdy", 32'(r3),      32'h0);
    v3 = 1'b0;
    step();
    chk("t3_apply3_rdy", 32'(r3), 32'h1);

    // 4: disable ch2 while high, then re-enable
    found = 1'b0;
    for (int e = 0; e < 20 && !found; e++) begin
      if (sq[2]) found = 1'b1;
      else       step();
    end
    chk("t4_found_high", 32'(found), 32'h1);
    ch_en[2] = 1'b0;
    step();
    chk("t4_sq2_low", 32'(sq[2]), 32'h0);
    ch_en[2] = 1'b1;
    for (int e = 0; e < 6; e++) step();

    // 5: program ch3 N=3 then sync everything
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd3;
    step();
    cfg_valid = 1'b0;
    step();
    sync_all = 1'b1;
    step();
    sync_all = 1'b0;
    chk("t5_sync_sq", 32'(sq), 32'h0);
    for (int e = 0; e < 8; e++) step();

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 15) == 0) ch_en[i] = ~ch_en[i];
      sync_all  = ($urandom_range(0, 39) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_half  = 8'($urandom_range(0, 6));
      step();
    end

    // 6: asynchronous reset while a request is pending and a wave is high
    sync_all = 1'b0;
    ch_en    = 4'hF;
    found    = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (pend_m && (sq_m != 0)) begin
        found = 1'b1;
      end else begin
        cfg_valid = 1'b1;
        cfg_ch    = 2'($urandom_range(0, 3));
        cfg_half  = 8'd6;
        step();
      end
    end
    cfg_valid = 1'b0;
    chk("t6_setup", 32'(found), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_async_sq",    32'(sq),        32'h0);
    chk("t6_async_tick",  32'(tick),      32'h0);
    chk("t6_async_ready", 32'(cfg_ready), 32'h1);
    model_reset();
    step();
    reset = 1'b0;
    for (int e = 0; e < 10; e++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
